fmap_writer: RTL and testbench
==============================

FMAP_WRITER -- requirements
Module: fmap_writer

Interface
REQ-001 Parameters (name, default, meaning): OUTPUT_NUM, 6, parallel output planes per write word.
REQ-002 OUT_W, 28, output plane width in results.
REQ-003 OUT_H, 28, output plane height in results.
REQ-004 OUTPUT_BATCH, 1, number of output batches per layer run.
REQ-005 ROW_PITCH, 32, address stride between rows; SHALL be >= OUT_W.
REQ-006 PLANE_PITCH, 1024, address stride between batches; SHALL be >= ROW_PITCH*OUT_H.
REQ-007 BASE_ADDR, 0, address of the first result.
REQ-008 AW, 16, address width.
REQ-009 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rstn, in, 1, reset; asynchronous, active-high.
- go, in, 1, one-cycle pulse that arms or re-arms the writer.
- en, in, 1, result valid (q_en of conv/relu/max_pool).
- data_i, in, `WDP*OUTPUT_NUM, result lanes.
- cenb, out, 1, memory write enable, active-low.
- ab, out, AW, write address.
- db, out, `WDP*OUTPUT_NUM, write data.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse on the final write.
- overflow, out, 1, sticky flag for an unexpected en.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE; reset enters IDLE.
REQ-011 go in any state SHALL enter RUN, zero the col/row/batch counters and clear overflow; a go mid-run SHALL restart cleanly.
REQ-012 In RUN, each en SHALL produce exactly one write, registered one cycle later: cenb=0, db=data_i (unmodified), ab as in REQ-013.
REQ-013 ab SHALL equal BASE_ADDR + batch*PLANE_PITCH + row*ROW_PITCH + col, truncated to AW bits (wrap, no error).
REQ-014 Counter order SHALL be: col increments per en; wraps at OUT_W-1 and advances row; row wraps at OUT_H-1 and advances batch.
REQ-015 Addresses SHALL be kept incrementally with no multipliers: row base += ROW_PITCH, plane base += PLANE_PITCH.
REQ-016 The en that completes col=OUT_W-1, row=OUT_H-1, batch=OUTPUT_BATCH-1 SHALL transition RUN->DONE.
REQ-017 done SHALL pulse on the same cycle as that final write (cenb=0).
REQ-018 DONE SHALL return to IDLE on the next cycle.
REQ-019 cenb SHALL be 1 in every cycle without a write; ab and db SHALL hold their last values.
REQ-020 en in IDLE or DONE SHALL be dropped (no write) and SHALL set overflow.
REQ-021 overflow SHALL stay set until go or reset.
REQ-022 If go and en are high in the same cycle, go wins: en is dropped and overflow is not set.
REQ-023 Back-to-back en (every cycle) SHALL be sustained at full rate with no bubbles.
REQ-024 busy SHALL be 1 exactly while in RUN.

Reset
REQ-025 Reset SHALL be asynchronous and active-high.
REQ-026 Reset values: state=IDLE, cenb=1, ab=0, db=0, busy=0, done=0, overflow=0, all counters 0.
REQ-027 Reset mid-run SHALL abort with no further writes; the first write after reset requires a new go.

Structure
REQ-028 `WDP, `CLK_RST_EDGE and `RST SHALL come from global.v; no new shared macros are required.
REQ-029 FSM state encodings SHALL be localparams inside the module.
REQ-030 One sub-module is natural: wr_addr_gen (counters, incremental bases, last flag); everything else lives in fmap_writer.

Verification
REQ-031 OUT_W=4, OUT_H=2, BATCH=2, ROW_PITCH=8, PLANE_PITCH=32, BASE=100; 16 consecutive en -> ab sequence 100,101,102,103,108..111,132..135,140..143 with one cycle latency; done pulses with ab=143; busy falls next cycle.
REQ-032 Same config, en every other cycle -> same 16 addresses in order; cenb=1 on the idle cycles; ab/db hold.
REQ-033 en with no prior go -> no write, overflow=1; then go -> overflow=0 and the first write goes to ab=100.
REQ-034 go after 5 writes -> next write goes to ab=100; done only after 16 further writes.
REQ-035 go and en in the same cycle -> that en produces no write and overflow stays 0; the next en writes ab=100.
REQ-036 Reset asserted after 3 writes -> cenb=1, ab=0, state IDLE immediately; later en without go -> overflow=1.

Source files
------------

// File: rtl/fmap_writer_pkg.sv
// Shared constants and helpers for the feature-map writer and its address generator.
package fmap_writer_pkg;

    localparam int WDP = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fmap_writer_wr_addr_gen.sv
// Col/row/batch counters with incrementally maintained row and plane base addresses.
module fmap_writer_wr_addr_gen
    import fmap_writer_pkg::*;
#(
    parameter int OUT_W        = 28,
    parameter int OUT_H        = 28,
    parameter int OUTPUT_BATCH = 1,
    parameter int ROW_PITCH    = 32,
    parameter int PLANE_PITCH  = 1024,
    parameter int BASE_ADDR    = 0,
    parameter int AW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int CW = cnt_w(OUT_W);
    localparam int RW = cnt_w(OUT_H);
    localparam int BW = cnt_w(OUTPUT_BATCH);

    localparam logic [AW-1:0] BASE_A = BASE_ADDR[AW-1:0];
    localparam logic [AW-1:0] ROW_A  = ROW_PITCH[AW-1:0];
    localparam logic [AW-1:0] PLANE_A = PLANE_PITCH[AW-1:0];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [BW-1:0] batch;
    logic [AW-1:0] row_base;
    logic [AW-1:0] plane_base;
    logic          col_last;
    logic          row_last;
    logic          batch_last;

    assign col_last   = (col == CW'(OUT_W - 1));
    assign row_last   = (row == RW'(OUT_H - 1));
    assign batch_last = (batch == BW'(OUTPUT_BATCH - 1));
    assign last       = col_last && row_last && batch_last;

    // row_base already includes plane_base, so the address is one add away.
    assign addr = row_base + AW'(col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            batch      <= '0;
            row_base   <= BASE_A;
            plane_base <= BASE_A;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            batch      <= '0;
            row_base   <= BASE_A;
            plane_base <= BASE_A;
        end else if (step) begin
            if (!col_last) begin
                col <= col + 1'b1;
            end else begin
                col <= '0;
                if (!row_last) begin
                    row      <= row + 1'b1;
                    row_base <= row_base + ROW_A;
                end else begin
                    row <= '0;
                    if (!batch_last) begin
                        batch      <= batch + 1'b1;
                        plane_base <= plane_base + PLANE_A;
                        row_base   <= plane_base + PLANE_A;
                    end else begin
                        batch      <= '0;
                        plane_base <= BASE_A;
                        row_base   <= BASE_A;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fmap_writer.sv
// Writes a stream of result words to memory in raster/batch order with one cycle of latency.
module fmap_writer
    import fmap_writer_pkg::*;
#(
    parameter int OUTPUT_NUM   = 6,
    parameter int OUT_W        = 28,
    parameter int OUT_H        = 28,
    parameter int OUTPUT_BATCH = 1,
    parameter int ROW_PITCH    = 32,
    parameter int PLANE_PITCH  = 1024,
    parameter int BASE_ADDR    = 0,
    parameter int AW           = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      go,
    input  logic                      en,
    input  logic [WDP*OUTPUT_NUM-1:0] data_i,
    output logic                      cenb,
    output logic [AW-1:0]             ab,
    output logic [WDP*OUTPUT_NUM-1:0] db,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [1:0]                fsm_state
);

    // Handshake: en is a single-cycle valid with no ready; in RUN every en is
    // accepted and written on the following cycle, elsewhere it is dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          stray;
    logic          last;
    logic [AW-1:0] addr;

    // go outranks en, so a coincident en is neither written nor flagged.
    assign accept    = (state == RUN) && en && !go;
    assign stray     = (state != RUN) && en && !go;
    assign busy      = (state == RUN);
    assign fsm_state = state;

    fmap_writer_wr_addr_gen #(
        .OUT_W       (OUT_W),
        .OUT_H       (OUT_H),
        .OUTPUT_BATCH(OUTPUT_BATCH),
        .ROW_PITCH   (ROW_PITCH),
        .PLANE_PITCH (PLANE_PITCH),
        .BASE_ADDR   (BASE_ADDR),
        .AW          (AW)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rstn),
        .clear(go),
        .step (accept),
        .addr (addr),
        .last (last)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (go) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:     if (accept && last) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cenb     <= 1'b1;
            ab       <= '0;
            db       <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cenb <= !accept;
            done <= accept && last;
            if (accept) begin
                ab <= addr;
                db <= data_i;
            end
            if (go)         overflow <= 1'b0;
            else if (stray) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fmap_writer.sv
// Randomized and directed bench for fmap_writer with a queue-based scoreboard.
module tb_fmap_writer;

    import fmap_writer_pkg::*;

    localparam int ON    = 6;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int B     = 2;
    localparam int RP    = 8;
    localparam int PP    = 32;
    localparam int BASE  = 100;
    localparam int AW    = 16;
    localparam int DW    = WDP * ON;
    localparam int TOTAL = W * H * B;

    typedef struct packed {
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          done;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          go;
    logic          en;
    logic [DW-1:0] data_i;
    logic          cenb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [1:0]    fsm_state;

    wr_t           exp_q[$];
    int            checks;
    int            errors;
    int            writes_seen;
    int            writes_exp;

    // Reference model state
    bit            m_armed;
    int            m_k;
    bit            m_ov;
    logic [AW-1:0] last_ab;
    logic [DW-1:0] last_db;

    fmap_writer #(
        .OUTPUT_NUM  (ON),
        .OUT_W       (W),
        .OUT_H       (H),
        .OUTPUT_BATCH(B),
        .ROW_PITCH   (RP),
        .PLANE_PITCH (PP),
        .BASE_ADDR   (BASE),
        .AW          (AW)
    ) dut (
        .clk      (clk),
        .rstn     (rst),
        .go       (go),
        .en       (en),
        .data_i   (data_i),
        .cenb     (cenb),
        .ab       (ab),
        .db       (db),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [AW-1:0] model_addr(input int k);
        int batch, row, col;
        batch = k / (W * H);
        row   = (k / W) % H;
        col   = k % W;
        return AW'(BASE + batch * PP + row * RP + col);
    endfunction

    function automatic void model_step(input bit g, input bit e, input logic [DW-1:0] d);
        wr_t w;
        if (g) begin
            m_armed = 1'b1;
            m_k     = 0;
            m_ov    = 1'b0;
        end else if (e) begin
            if (m_armed) begin
                w.ab   = model_addr(m_k);
                w.db   = d;
                w.done = (m_k == TOTAL - 1);
                exp_q.push_back(w);
                writes_exp++;
                m_k++;
                if (m_k == TOTAL) m_armed = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // driver: inputs change 1 time unit after the edge
    task automatic cycle(input bit g, input bit e);
        logic [DW-1:0] d;
        d      = rand_data();
        go     = g;
        en     = e;
        data_i = d;
        @(posedge clk);
        model_step(g, e, d);
        #1;
        go = 1'b0;
        en = 1'b0;
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_k     = 0;
        m_ov    = 1'b0;
        last_ab = '0;
        last_db = '0;
        exp_q.delete();
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (cenb === 1'b0) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got ab=%0d, expected no write at %0t", ab, $time);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("ab", 64'(ab), 64'(w.ab));
                    check("db", 64'(db), 64'(w.db));
                    check("done", 64'(done), 64'(w.done));
                    last_ab = w.ab;
                    last_db = w.db;
                end
            end else begin
                check("done_idle", 64'(done), 64'd0);
                check("ab_hold", 64'(ab), 64'(last_ab));
                check("db_hold", 64'(db), 64'(last_db));
            end
            check("busy", 64'(busy), 64'(m_armed));
            check("overflow", 64'(overflow), 64'(m_ov));
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        writes_seen = 0;
        writes_exp  = 0;
        go          = 1'b0;
        en          = 1'b0;
        data_i      = '0;
        rst         = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cenb", 64'(cenb), 64'd1);
        check("rst_ab", 64'(ab), 64'd0);
        check("rst_db", 64'(db), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        rst = 1'b0;

        // en before any go, then a full back-to-back run
        cycle(0, 1);
        cycle(0, 0);
        cycle(1, 0);
        for (int i = 0; i < TOTAL; i++) cycle(0, 1);
        cycle(0, 0);
        cycle(0, 0);

        // en every other cycle
        cycle(1, 0);
        for (int i = 0; i < TOTAL; i++) begin
            cycle(0, 1);
            cycle(0, 0);
        end

        // restart after 5 writes
        cycle(1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1);
        cycle(1, 0);
        for (int i = 0; i < TOTAL; i++) cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);

        // go and en together
        cycle(1, 0);
        cycle(0, 1);
        cycle(1, 1);
        for (int i = 0; i < TOTAL; i++) cycle(0, 1);
        cycle(0, 0);

        // asynchronous reset mid-run
        cycle(1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1);
        cycle(0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_cenb", 64'(cenb), 64'd1);
        check("midrst_ab", 64'(ab), 64'd0);
        check("midrst_state", 64'(fsm_state), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("write_count", 64'(writes_seen), 64'(writes_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
